// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that feeds bytes from N_REQ requesters
// into a single UART serializer, with per-grant bursts, an inter-byte gap
// and a sticky timeout flag for a serializer that never reports done.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module uart_tx_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = `UART_DATA_WIDTH,
  parameter int MAX_BURST  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ*DATA_W-1:0]    req_data_i,
  input  logic [N_REQ-1:0]           req_v_i,
  output logic [N_REQ-1:0]           req_rdy_o,
  output logic [DATA_W-1:0]          ser_data_o,
  output logic                       ser_v_o,
  input  logic                       ser_done_i,
  output logic [$clog2(N_REQ)-1:0]   grant_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int GW = $clog2(N_REQ);

  // Expiry fires on the WAIT cycle whose increment would make the counter
  // reach TIMEOUT-1, so the flag shows TIMEOUT cycles after the strobe.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 2);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [4:0]  BURST_MAX = 5'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4
  } state_e;

  state_e             state_q;
  logic [GW-1:0]      rr_q;
  logic [GW-1:0]      grant_q;
  logic [4:0]         burst_q;
  logic [15:0]        tmo_q;
  logic [3:0]         gap_q;
  logic [DATA_W-1:0]  data_q;
  logic               sv_q;
  logic               err_q;

  logic [GW-1:0]      win_idx;
  logic [GW-1:0]      cand_idx;
  int                 cand;
  logic [DATA_W-1:0]  sel_data;
  logic               stay_d;
  logic [GW-1:0]      next_rr_d;

  // Pointer to the requester after g, wrapping at N_REQ.
  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
    if (g == GW'(N_REQ - 1)) begin
      return '0;
    end else begin
      return g + GW'(1);
    end
  endfunction

  // Round-robin search: first active requester starting at rr_q.
  always_comb begin
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end else begin
        cand = cand + 0;
      end
      cand_idx = GW'(cand);
      if (req_v_i[cand_idx]) begin
        win_idx = cand_idx;
      end else begin
        win_idx = win_idx;
      end
    end
  end

  // Byte of the current owner, burst continuation test and release pointer.
  always_comb begin
    sel_data  = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
    stay_d    = req_v_i[grant_q] && (burst_q < BURST_MAX);
    next_rr_d = next_ptr(grant_q);
  end

  // Acceptance pulse to the granted requester while it is being served.
  always_comb begin
    req_rdy_o = '0;
    if ((state_q == S_ISSUE) && req_v_i[grant_q]) begin
      req_rdy_o[grant_q] = 1'b1;
    end else begin
      req_rdy_o = '0;
    end
  end

  // Arbitration / issue / wait / gap sequencer with all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      burst_q <= 5'd0;
      tmo_q   <= 16'd0;
      gap_q   <= 4'd0;
      data_q  <= '0;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_v_i) begin
            grant_q <= win_idx;
            burst_q <= 5'd0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_v_i[grant_q]) begin
            data_q  <= sel_data;
            burst_q <= burst_q + 5'd1;
            sv_q    <= 1'b1;
            state_q <= S_STROBE;
          end else begin
            rr_q    <= next_rr_d;
            state_q <= S_IDLE;
          end
        end
        S_STROBE: begin
          tmo_q   <= 16'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (ser_done_i) begin
            if (GAP_CYCLES == 0) begin
              if (stay_d) begin
                state_q <= S_ISSUE;
              end else begin
                rr_q    <= next_rr_d;
                state_q <= S_IDLE;
              end
            end else begin
              gap_q   <= 4'd0;
              state_q <= S_GAP;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            rr_q    <= next_rr_d;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (stay_d) begin
              state_q <= S_ISSUE;
            end else begin
              rr_q    <= next_rr_d;
              state_q <= S_IDLE;
            end
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ser_data_o = data_q;
  assign ser_v_o    = sv_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != S_IDLE);
  assign err_o      = err_q;

endmodule
